// File: rtl/siso_frame_rx.sv
// ============================================================================
//  siso_frame_rx : serial frame receiver (start, LSB-first data, even parity,
//                  stop) with held parallel output and valid/ack handshake.
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module siso_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int c_CW = $clog2(DATA_W);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DATA_W - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [c_CW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_xor;
  logic              r_mis;

  logic w_start;
  logic w_shift;
  logic w_par;
  logic w_stop_ok;
  logic w_stop_bad;
  logic w_deliver;
  logic w_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (si) w_next = c_DATA;
      c_DATA:   if (r_cnt == c_LAST) w_next = c_PARITY;
      c_PARITY: w_next = c_STOP;
      c_STOP:   w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_start    = (r_state == c_IDLE) && si;
    w_shift    = (r_state == c_DATA);
    w_par      = (r_state == c_PARITY);
    w_stop_ok  = (r_state == c_STOP) && !si;
    w_stop_bad = (r_state == c_STOP) && si;
    // A pending word may be replaced only if it is being taken on this edge.
    w_deliver  = w_stop_ok && (!out_valid || out_ack);
    w_ack      = out_valid && out_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_xor      <= 1'b0;
      r_mis      <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;

      if (w_start) begin
        r_cnt <= '0;
        r_xor <= 1'b0;
      end

      if (w_shift) begin
        r_shift[r_cnt] <= si;
        r_xor          <= r_xor ^ si;
        if (r_cnt != c_LAST) r_cnt <= r_cnt + c_ONE;
      end

      if (w_par) r_mis <= r_xor ^ si;

      if (w_deliver) begin
        data_out   <= r_shift;
        parity_err <= r_mis;
        out_valid  <= 1'b1;
      end else if (w_ack) begin
        out_valid  <= 1'b0;
      end

      // A dropped good frame sets overrun; any accepted ack clears it.
      if (w_stop_ok && !w_deliver) overrun <= 1'b1;
      else if (w_ack)              overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_siso_frame_rx.sv
// ============================================================================
//  tb_siso_frame_rx : directed self-checking bench for siso_frame_rx.
//  Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_siso_frame_rx;

  logic       clk;
  logic       rst;
  logic       si;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ack;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_vec;
  int n_err;

  siso_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .si         (si),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one full frame; ack_stop raises out_ack on the stop-bit edge only.
  task automatic send(input logic [7:0] d, input logic p, input logic stop, input logic ack_stop);
    si = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      si = d[i];
      tick();
    end
    si = p;
    tick();
    si      = stop;
    out_ack = ack_stop;
    tick();
    si      = 1'b0;
    out_ack = 1'b0;
  endtask

  task automatic ack_once();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    si      = 1'b0;
    out_ack = 1'b0;
    #3;
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_data", 16'(data_out), 16'h0);
    chk("rst_flags", {13'd0, parity_err, frame_err, overrun}, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 0xA5, correct parity 0: out_valid must rise exactly on the 11th edge.
    si = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      si = (8'hA5 >> i) & 1'b1;
      tick();
    end
    si = 1'b0;
    tick();
    chk("a5_not_early", 16'(out_valid), 16'h0);
    si = 1'b0;
    tick();
    chk("a5_valid", 16'(out_valid), 16'h1);
    chk("a5_data", 16'(data_out), 16'h00A5);
    chk("a5_perr", 16'(parity_err), 16'h0);
    ack_once();
    chk("a5_ack_clears", 16'(out_valid), 16'h0);
    chk("a5_data_held", 16'(data_out), 16'h00A5);

    // 0x3C has even weight, so P=1 is wrong.
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("3c_valid", 16'(out_valid), 16'h1);
    chk("3c_data", 16'(data_out), 16'h003C);
    chk("3c_perr", 16'(parity_err), 16'h1);
    chk("3c_ferr", 16'(frame_err), 16'h0);
    ack_once();
    chk("3c_ack_clears", 16'(out_valid), 16'h0);

    // Bad stop bit.
    send(8'h0F, 1'b0, 1'b1, 1'b0);
    chk("0f_ferr_pulse", 16'(frame_err), 16'h1);
    chk("0f_no_valid", 16'(out_valid), 16'h0);
    chk("0f_data_kept", 16'(data_out), 16'h003C);
    tick();
    chk("0f_ferr_one_cycle", 16'(frame_err), 16'h0);

    // Back-to-back without ack: second word dropped, overrun set.
    send(8'h11, 1'b0, 1'b0, 1'b0);
    chk("b2b_first_data", 16'(data_out), 16'h0011);
    chk("b2b_first_perr", 16'(parity_err), 16'h0);
    send(8'h22, 1'b0, 1'b0, 1'b0);
    chk("b2b_data_kept", 16'(data_out), 16'h0011);
    chk("b2b_overrun", 16'(overrun), 16'h1);
    chk("b2b_valid", 16'(out_valid), 16'h1);
    ack_once();
    chk("b2b_ack_valid", 16'(out_valid), 16'h0);
    chk("b2b_ack_overrun", 16'(overrun), 16'h0);
    ack_once();
    chk("stray_ack_ignored", 16'(out_valid), 16'h0);

    // Back-to-back with ack on the second stop edge: second word replaces first.
    send(8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b1);
    chk("b2b_ack_data", 16'(data_out), 16'h0022);
    chk("b2b_ack_valid_hi", 16'(out_valid), 16'h1);
    chk("b2b_ack_no_overrun", 16'(overrun), 16'h0);

    // Reset mid-frame at data bit 4, asserted away from any clock edge.
    si = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      si = (8'hFF >> i) & 1'b1;
      tick();
    end
    si = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 16'(out_valid), 16'h0);
    chk("async_rst_data", 16'(data_out), 16'h0);
    si = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 16'(out_valid), 16'h0);
    send(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("5a_valid", 16'(out_valid), 16'h1);
    chk("5a_data", 16'(data_out), 16'h005A);
    chk("5a_flags", {13'd0, parity_err, frame_err, overrun}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
